// File: rtl/microsequencer.sv
// Next-state address generator for the microprogrammed control unit: selects the
// microstore address each cycle and bounds memory-complete wait loops with a timeout.
module microsequencer #(
    parameter int                 STATE_W   = 10,
    parameter int                 TIMEOUT   = 15,
    parameter logic [STATE_W-1:0] ERR_STATE = 10'd30
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [2:0]         N,
    input  logic               inv,
    input  logic [1:0]         select,
    input  logic [5:0]         cr,
    input  logic [STATE_W-1:0] enc_state,
    input  logic               moc,
    input  logic               cond,
    output logic [STATE_W-1:0] next_state,
    output logic               timeout_err
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    localparam logic [2:0] N_FETCH  = 3'b000;
    localparam logic [2:0] N_ENC    = 3'b001;
    localparam logic [2:0] N_LIT    = 3'b010;
    localparam logic [2:0] N_INCR   = 3'b011;
    localparam logic [2:0] N_BR_LIT = 3'b100;
    localparam logic [2:0] N_BR_ENC = 3'b101;
    localparam logic [2:0] N_WAIT   = 3'b110;
    localparam logic [2:0] N_HALT   = 3'b111;

    logic [STATE_W-1:0] state_reg;
    logic [STATE_W-1:0] incr_reg;
    logic [7:0]         wait_cnt;

    logic               sel_src;
    logic               c;
    logic               hold;
    logic               timeout_hit;
    logic [STATE_W-1:0] cr_ext;
    logic [STATE_W-1:0] addr_sel;

    assign cr_ext = {{(STATE_W-6){1'b0}}, cr};

    always_comb begin
        sel_src = 1'b0;
        case (select)
            2'b00:   sel_src = moc;
            2'b01:   sel_src = cond;
            2'b10:   sel_src = 1'b1;
            default: sel_src = 1'b0;
        endcase
    end

    assign c = sel_src ^ inv;

    // A false condition in the wait loop is a hold; the hold that finds the
    // counter at the limit becomes the error redirect instead.
    assign timeout_hit = (N == N_WAIT) && !c && (wait_cnt == TIMEOUT_CNT);
    assign hold        = (N == N_WAIT) && !c && !timeout_hit;

    always_comb begin
        addr_sel = '0;
        case (N)
            N_FETCH:  addr_sel = '0;
            N_ENC:    addr_sel = enc_state;
            N_LIT:    addr_sel = cr_ext;
            N_INCR:   addr_sel = incr_reg;
            N_BR_LIT: addr_sel = c ? cr_ext : incr_reg;
            N_BR_ENC: addr_sel = c ? enc_state : incr_reg;
            N_WAIT:   addr_sel = c ? incr_reg : (timeout_hit ? ERR_STATE : state_reg);
            N_HALT:   addr_sel = state_reg;
            default:  addr_sel = '0;
        endcase
    end

    assign next_state = reset_n ? addr_sel : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= '0;
            incr_reg    <= STATE_W'(1);
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            state_reg   <= next_state;
            incr_reg    <= next_state + STATE_W'(1);
            wait_cnt    <= hold ? wait_cnt + 8'd1 : 8'd0;
            timeout_err <= timeout_hit;
        end
    end

endmodule

// File: tb/tb_microsequencer.sv
// Randomized and directed scoreboard bench for microsequencer against an
// abstract model of the sequencing rules.
module tb_microsequencer;

    localparam int TIMEOUT = 15;
    localparam int ERR_ST  = 30;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [2:0] N = 3'd0;
    logic       inv = 1'b0;
    logic [1:0] select = 2'd0;
    logic [5:0] cr = 6'd0;
    logic [9:0] enc_state = 10'd0;
    logic       moc = 1'b0;
    logic       cond = 1'b0;
    logic [9:0] next_state;
    logic       timeout_err;

    microsequencer #(.STATE_W(10), .TIMEOUT(TIMEOUT), .ERR_STATE(10'd30)) dut (
        .clk(clk), .reset_n(reset_n), .N(N), .inv(inv), .select(select), .cr(cr),
        .enc_state(enc_state), .moc(moc), .cond(cond),
        .next_state(next_state), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Reference model: current address, consecutive holds, pending error flag.
    int m_state = 0;
    int m_holds = 0;
    bit m_terr  = 0;

    int    exp_ns_q[$];
    bit    exp_te_q[$];
    string tag_q[$];
    int    vectors = 0;
    int    miscompares = 0;
    string cur_tag = "reset";

    always @(negedge clk) begin
        if (exp_ns_q.size() > 0) begin
            int    ens;
            bit    ete;
            string t;
            ens = exp_ns_q.pop_front();
            ete = exp_te_q.pop_front();
            t   = tag_q.pop_front();
            vectors++;
            if (next_state !== 10'(ens) || timeout_err !== ete) begin
                miscompares++;
                $display("FAIL %s: next_state=%0d timeout_err=%b, required next_state=%0d timeout_err=%b",
                         t, next_state, timeout_err, ens, ete);
            end
        end
    end

    function automatic void model_eval(output int ns, output bit redirect, output bit is_hold);
        bit src, cv;
        int incr;
        incr = (m_state + 1) % 1024;
        case (select)
            2'd0: src = moc;
            2'd1: src = cond;
            2'd2: src = 1'b1;
            default: src = 1'b0;
        endcase
        cv = src ^ inv;
        redirect = 0;
        is_hold  = 0;
        case (N)
            3'd0: ns = 0;
            3'd1: ns = int'(enc_state);
            3'd2: ns = int'(cr);
            3'd3: ns = incr;
            3'd4: ns = cv ? int'(cr) : incr;
            3'd5: ns = cv ? int'(enc_state) : incr;
            3'd6: begin
                if (cv) ns = incr;
                else if (m_holds == TIMEOUT) begin ns = ERR_ST; redirect = 1; end
                else begin ns = m_state; is_hold = 1; end
            end
            default: ns = m_state;
        endcase
    endfunction

    // One clock cycle with the given inputs: expectation queued, then the edge.
    task automatic step(input bit [2:0] n, input bit iv, input bit [1:0] sel, input bit [5:0] c_r,
                        input bit [9:0] enc, input bit m, input bit cd);
        int ns;
        bit rd, hd;
        N = n; inv = iv; select = sel; cr = c_r; enc_state = enc; moc = m; cond = cd;
        model_eval(ns, rd, hd);
        exp_ns_q.push_back(ns);
        exp_te_q.push_back(m_terr);
        tag_q.push_back(cur_tag);
        @(posedge clk);
        m_state = ns;
        m_holds = hd ? m_holds + 1 : 0;
        m_terr  = rd;
        #1;
    endtask

    // Reset asserted asynchronously mid-cycle, held across two edges.
    task automatic do_reset();
        reset_n = 1'b0;
        N = 3'b010; cr = 6'd20;
        m_state = 0; m_holds = 0; m_terr = 0;
        #1;
        repeat (2) begin
            exp_ns_q.push_back(0);
            exp_te_q.push_back(0);
            tag_q.push_back(cur_tag);
            @(posedge clk);
            #1;
        end
        reset_n = 1'b1;
    endtask

    initial begin
        int steps;
        int w;
        @(posedge clk);
        #1;
        cur_tag = "reset_hold";
        do_reset();

        cur_tag = "reset_release_incr";
        repeat (3) step(3'b011, 0, 2'b00, 6'd0, 10'd0, 0, 0);

        cur_tag = "branch_taken";
        step(3'b100, 0, 2'b01, 6'd4, 10'd0, 0, 1);
        cur_tag = "branch_inverted";
        step(3'b100, 1, 2'b01, 6'd4, 10'd0, 0, 1);

        cur_tag = "encoder_dispatch";
        step(3'b001, 0, 2'b00, 6'd0, 10'd20, 0, 0);
        cur_tag = "dispatch_incr";
        step(3'b011, 0, 2'b00, 6'd0, 10'd0, 0, 0);

        cur_tag = "wait_setup";
        step(3'b010, 0, 2'b00, 6'd7, 10'd0, 0, 0);
        cur_tag = "wait_hold";
        repeat (3) step(3'b110, 0, 2'b00, 6'd0, 10'd0, 0, 0);
        cur_tag = "wait_exit";
        step(3'b110, 0, 2'b00, 6'd0, 10'd0, 1, 0);
        cur_tag = "post_wait_incr";
        step(3'b011, 0, 2'b00, 6'd0, 10'd0, 0, 0);

        cur_tag = "timeout";
        repeat (TIMEOUT + 3) step(3'b110, 0, 2'b00, 6'd0, 10'd0, 0, 0);
        cur_tag = "timeout_after";
        step(3'b011, 0, 2'b00, 6'd0, 10'd0, 0, 0);

        cur_tag = "wrap_setup";
        step(3'b010, 0, 2'b00, 6'd63, 10'd0, 0, 0);
        cur_tag = "wrap_incr";
        repeat (1023 - 63 + 2) step(3'b011, 0, 2'b00, 6'd0, 10'd0, 0, 0);

        cur_tag = "midwait_holds";
        repeat (5) step(3'b110, 0, 2'b00, 6'd0, 10'd0, 0, 0);
        cur_tag = "midwait_reset";
        do_reset();
        cur_tag = "post_reset_wait";
        repeat (TIMEOUT + 2) step(3'b110, 1, 2'b00, 6'd0, 10'd0, 1, 0);

        cur_tag = "random";
        steps = 0;
        while (steps < 3000) begin
            w = $urandom_range(0, 99);
            if (w < 2) begin
                do_reset();
                steps += 2;
            end else if (w < 8) begin
                repeat ($urandom_range(10, 20)) begin
                    step(3'b110, 0, 2'b00, 6'($urandom), 10'($urandom), $urandom_range(0, 15) == 0, 1'($urandom));
                    steps++;
                end
            end else begin
                step(3'($urandom), 1'($urandom), 2'($urandom), 6'($urandom), 10'($urandom),
                     1'($urandom), 1'($urandom));
                steps++;
            end
        end

        repeat (4) begin
            if (exp_ns_q.size() > 0) @(negedge clk);
        end
        #1;
        if (exp_ns_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, required 0", exp_ns_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/microsequencer.md
# microsequencer

Next-state address generator for the microprogrammed control unit. It sits directly upstream of the microstore and drives its 10-bit `next_state` address. It consumes the sequencing fields (`N`, `inv`, `select`, `cr`) latched by the control register, plus the instruction encoder's entry state and status conditions. It holds the current-state and incrementer registers and enforces a bounded wait on memory-complete loops.

## Interface
- `STATE_W`, 10, width of microstore address
- `TIMEOUT`, 15, maximum consecutive hold cycles in a wait loop (1..255)
- `ERR_STATE`, 10'd30, microstore address forced on wait timeout
- `clk`  in  1  system clock, all state updates on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `N`  in  3  next-state action, from control register
- `inv`  in  1  invert selected condition, from control register
- `select`  in  2  condition source select, from control register
- `cr`  in  6  literal target state, from control register; zero-extended to 10 bits
- `enc_state`  in  10  entry state from instruction encoder
- `moc`  in  1  memory operation complete
- `cond`  in  1  condition-tester result (branch taken)
- `next_state`  out  10  microstore address
- `timeout_err`  out  1  one-cycle pulse after a wait timeout redirect

## Operation
- Registers:
  - `state_reg` (10) holds the current state.
  - `incr_reg` (10) holds `next_state + 1`.
  - `wait_cnt` (8) counts consecutive holds.
  - `timeout_err` (1).
- Condition: `c = sel_src ^ inv`. `sel_src` by `select` is: 00 `moc`, 01 `cond`, 10 constant 1, 11 constant 0.
- `next_state` is combinational, chosen by `N`:
  - 000: 0 (fetch vector)
  - 001: `enc_state`
  - 010: `{4'b0, cr}`
  - 011: `incr_reg`
  - 100: `c ? {4'b0,cr} : incr_reg`
  - 101: `c ? enc_state : incr_reg`
  - 110: `c ? incr_reg : state_reg` (wait loop; a false condition is a "hold")
  - 111: `state_reg` (halt; never counts toward timeout)
- Timeout rule: if `N`=110, `c`=0 and `wait_cnt == TIMEOUT`, `next_state = ERR_STATE` instead of `state_reg`.
- On every rising edge (reset inactive):
  - `state_reg <= next_state`.
  - `incr_reg <= next_state + 1`, mod 2^10, so 1023 wraps to 0.
  - `wait_cnt`: +1 on a hold; cleared on any other selection, including the timeout redirect.
  - `timeout_err <= 1` only on the edge that loads `ERR_STATE` via timeout, else 0.
- Reset (`reset_n`=0, asynchronous):
  - `state_reg`=0, `incr_reg`=1, `wait_cnt`=0, `timeout_err`=0.
  - `next_state` is forced to 0 while reset is asserted, regardless of inputs.
- Reset mid-wait aborts the loop: the count restarts at 0 and the address returns to 0.

## Timing
- `next_state` has zero-cycle latency from `N`/`inv`/`select`/`cr`/`enc_state`/`moc`/`cond`. The control register loads the microstore word at the same edge that loads `state_reg`.
- Incrementing sequence: with `N`=011 held, `next_state` after edge k is `state_k + 1`, one step per cycle.
- Wait loop:
  - `moc` rising while `N`=110, `select`=00, `inv`=0 gives `next_state = incr_reg` in the same cycle.
  - Exit occurs at the next edge.
- Timeout:
  - After exactly `TIMEOUT` hold edges, the following cycle shows `ERR_STATE`.
  - `timeout_err` is high for the one cycle after that edge.
- `timeout_err` is registered and glitch-free. `next_state` may glitch within a cycle; only the value at the edge matters.
- Reset release is asynchronous. The first edge after release loads from the inputs present then.

## Test plan
- **Reset:** hold `reset_n`=0 with `N`=010, `cr`=6'd20.
  - Required: `next_state`=0 and `timeout_err`=0.
  - After release with `N`=011: `next_state` 1, 2, 3 on successive cycles.
- **Branch:** `N`=100, `select`=01, `cr`=6'd4.
  - `cond`=1, `inv`=0: `next_state`=4.
  - `cond`=1, `inv`=1: `next_state` = `state_reg + 1`.
- **Encoder dispatch:** `N`=001, `enc_state`=10'd20 → `next_state`=20. Next cycle with `N`=011 → 21.
- **Wait loop:** `N`=110, `select`=00, state 7, `moc`=0 for 3 cycles, then 1.
  - Required: `next_state` 7, 7, 7, then 8.
  - `wait_cnt` returns to 0; `timeout_err` stays 0.
- **Timeout:** `N`=110, `moc` held 0, `TIMEOUT`=15.
  - Required: 15 cycles at the same state, then `next_state`=30.
  - `timeout_err`=1 for exactly one cycle.
- **Wrap and mid-wait reset:**
  - `N`=010 to reach state 63, then `N`=011 repeatedly to 1023: next value is 0.
  - Assert `reset_n` during a wait: `next_state`=0 immediately and `wait_cnt` cleared.
